conv3x3_engine: RTL and testbench
=================================

Name: conv3x3_engine

Overview:
- Sits directly downstream of the 4096x8 image RAM.
- Owns the RAM read port: r_en, plus the 12-bit address.
- Fetches each 3x3 neighbourhood of the stored 64x64 grayscale image, multiplies it by a signed 3x3 kernel, scales and clamps the sum, and streams one 8-bit result per valid window over a valid/ready handshake to the output buffer.
- Only interior windows are produced, giving a (W-2)x(H-2) output image.

Parameters:
IMG_W, 64, image width in pixels
IMG_H, 64, image height in pixels
ADDR_W, 12, RAM address width; IMG_W*IMG_H <= 2**ADDR_W
SHIFT, 4, arithmetic right shift applied to the accumulated sum

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a full-image convolution; sampled only in IDLE
kernel  input  72  9 signed 8-bit coefficients; tap k=3*dy+dx occupies bits [8k+7:8k]
mem_r_en  output  1  read enable to image RAM
mem_addr  output  ADDR_W  read address to image RAM
mem_rdata  input  8  RAM data_out; valid the cycle after mem_r_en
out_valid  output  1  out_data/out_addr hold a result
out_ready  input  1  consumer accepts the result when high with out_valid
out_data  output  8  clamped convolution result
out_addr  output  ADDR_W  output pixel index r*(IMG_W-2)+c
busy  output  1  high in READ, DRAIN and EMIT
done  output  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (asynchronous, active-high):
  - State returns to IDLE.
  - All outputs go to 0; r, c, tap and acc go to 0.
  - This applies from any state, including mid-window; no partial result is emitted.
- States: IDLE, READ, DRAIN, EMIT, DONE.
- IDLE:
  - start=1 latches kernel into an internal register and sets r=c=0, tap=0, acc=0.
  - Next state is READ.
  - Changes to kernel after start are ignored until the next run.
  - start is ignored in every state other than IDLE.
- READ (exactly 9 cycles, tap 0..8):
  - mem_r_en=1.
  - mem_addr = (r+tap/3)*IMG_W + (c+tap%3), taps in row-major order.
  - After tap 8, next state is DRAIN.
- Accumulation:
  - One cycle after each read, acc += $unsigned(mem_rdata) * $signed(coef[tap-1]).
  - acc is a 20-bit signed register (range ±293760 fits).
- DRAIN (1 cycle):
  - mem_r_en=0.
  - At the exit edge, out_data loads clamp((acc + p8*coef8) >>> SHIFT).
  - clamp: values <0 become 0; values >255 become 255.
  - out_addr loads r*(IMG_W-2)+c.
  - out_valid is set to 1.
- EMIT:
  - out_valid=1 with out_data and out_addr held stable until out_valid && out_ready at a rising edge.
  - No RAM reads are issued while stalled.
  - On handshake, out_valid goes to 0 and acc is cleared.
  - Coordinate advance: c+1; if c==IMG_W-3 then c=0 and r+1.
  - If the accepted result was r==IMG_H-3 and c==IMG_W-3, next state is DONE; otherwise READ.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Timing:
  - Start sampled at edge 0 gives READ in cycles 1-9, DRAIN in cycle 10 and EMIT from cycle 11.
  - With out_ready held high, the cost is 11 cycles per output pixel.
  - A full default run is 3844 results; done rises in cycle 3844*11+1.
- Output order: strictly raster, out_addr 0,1,...,(IMG_W-2)*(IMG_H-2)-1 with no gaps or repeats.
- mem_r_en is never asserted outside READ. mem_addr is held at its last value when not reading.

Test Plan:
- Identity kernel (centre=16, rest 0, SHIFT=4), RAM[a]=a mod 256, start -> first handshake out_addr=0, out_data=65; out_addr=61 gives data 126; out_addr=62 gives data 129 (addr 129).
- Box kernel (all 1), constant image 200 -> every result 1800>>>4=112; 3844 handshakes; done pulses exactly once, 1 cycle.
- Saturation:
  - All coefficients 127 on image 255 -> out_data=255.
  - Centre -128, rest 0 on image 255 -> out_data=0.
- Backpressure: out_ready low for 5 cycles at the first result -> out_valid, out_data and out_addr constant, mem_r_en=0 during the stall; result accepted on the 6th cycle, then READ resumes the next cycle.
- Timing/ordering with out_ready=1:
  - mem_r_en high exactly 9 consecutive cycles per pixel.
  - mem_addr sequence for the first pixel is 0,1,2,64,65,66,128,129,130.
  - Pixel period is 11 cycles; out_addr is monotonic 0..3843.
- Robustness:
  - start pulsed while busy -> no effect.
  - rst asserted in READ of pixel 10 -> outputs 0 immediately (asynchronously).
  - A new start after reset restarts at out_addr=0 with correct data.

Source files
------------

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: walks every interior 3x3 window of the image held in the
// upstream RAM, convolves it with a latched signed kernel, scales by an
// arithmetic right shift, clamps to 0..255 and hands each result to the
// output buffer over a valid/ready handshake in raster order.
module conv3x3_engine #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 12,
   parameter int SHIFT  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [71:0]       kernel,
   output logic              mem_r_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_EMIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]          state_reg;
   logic [ADDR_W-1:0]   r_reg, c_reg;
   logic [3:0]          tap_reg;     // index of the read currently on the RAM port
   logic signed [19:0]  acc_reg;
   logic [71:0]         kernel_reg;

   logic signed [7:0]   coef [9];
   logic signed [7:0]   coef_sel;
   logic signed [19:0]  prod, sum, shifted;
   logic [7:0]          clamp_val;
   logic                last_col, last_px;
   logic [ADDR_W-1:0]   r_next, c_next;

   // Unpack the latched kernel into its nine signed taps
   generate
      for (genvar gi = 0; gi < 9; gi++) begin : g_coef
         assign coef[gi] = kernel_reg[8*gi +: 8];
      end
   endgenerate

   // RAM address of tap t of the window whose top-left corner is (rr, cc)
   function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] rr,
                                                  input logic [ADDR_W-1:0] cc,
                                                  input logic [3:0] t);
      int unsigned dy, dx, a;
      dy = (t >= 4'd6) ? 2 : ((t >= 4'd3) ? 1 : 0);
      dx = 32'(t) - 3 * dy;
      a  = (32'(rr) + dy) * unsigned'(IMG_W) + 32'(cc) + dx;
      return a[ADDR_W-1:0];
   endfunction

   // Linear index of output pixel (rr, cc) in the shrunken image
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] rr,
                                                  input logic [ADDR_W-1:0] cc);
      int unsigned a;
      a = 32'(rr) * unsigned'(IMG_W - 2) + 32'(cc);
      return a[ADDR_W-1:0];
   endfunction

   // The data on mem_rdata belongs to the previous tap, so pair it with that coefficient
   always_comb begin
      coef_sel = '0;
      if (tap_reg != 4'd0 && tap_reg <= 4'd9)
         coef_sel = coef[tap_reg - 4'd1];
   end

   assign prod    = $signed({12'd0, mem_rdata}) * $signed({{12{coef_sel[7]}}, coef_sel});
   assign sum     = acc_reg + prod;
   assign shifted = sum >>> SHIFT;

   // Saturate the scaled sum into an unsigned byte
   always_comb begin
      clamp_val = shifted[7:0];
      if (shifted < 20'sd0)
         clamp_val = 8'd0;
      else if (shifted > 20'sd255)
         clamp_val = 8'd255;
   end

   assign last_col = (c_reg == ADDR_W'(IMG_W - 3));
   assign last_px  = last_col && (r_reg == ADDR_W'(IMG_H - 3));
   assign c_next   = last_col ? '0 : c_reg + 1'b1;
   assign r_next   = last_col ? r_reg + 1'b1 : r_reg;

   assign busy = (state_reg == S_READ) || (state_reg == S_DRAIN) || (state_reg == S_EMIT);

   // Control FSM, read sequencing, accumulation and output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         r_reg      <= '0;
         c_reg      <= '0;
         tap_reg    <= '0;
         acc_reg    <= '0;
         kernel_reg <= '0;
         mem_r_en   <= 1'b0;
         mem_addr   <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_addr   <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  kernel_reg <= kernel;
                  r_reg      <= '0;
                  c_reg      <= '0;
                  tap_reg    <= '0;
                  acc_reg    <= '0;
                  mem_r_en   <= 1'b1;
                  mem_addr   <= tap_addr('0, '0, 4'd0);
                  state_reg  <= S_READ;
               end
            end
            S_READ: begin
               acc_reg <= sum;
               tap_reg <= tap_reg + 4'd1;
               if (tap_reg == 4'd8) begin
                  // address stays on tap 8; the last product is folded in during DRAIN
                  mem_r_en  <= 1'b0;
                  state_reg <= S_DRAIN;
               end else begin
                  mem_addr <= tap_addr(r_reg, c_reg, tap_reg + 4'd1);
               end
            end
            S_DRAIN: begin
               out_data  <= clamp_val;
               out_addr  <= pix_addr(r_reg, c_reg);
               out_valid <= 1'b1;
               state_reg <= S_EMIT;
            end
            S_EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc_reg   <= '0;
                  tap_reg   <= '0;
                  r_reg     <= r_next;
                  c_reg     <= c_next;
                  if (last_px) begin
                     done      <= 1'b1;
                     state_reg <= S_DONE;
                  end else begin
                     mem_r_en  <= 1'b1;
                     mem_addr  <= tap_addr(r_next, c_next, 4'd0);
                     state_reg <= S_READ;
                  end
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine: a RAM model feeds the engine, a
// window-level reference computes each expected pixel straight from the
// image and kernel, and a negedge monitor checks every accepted result.
module tb_conv3x3_engine;

   localparam int W    = 64;
   localparam int H    = 64;
   localparam int AW   = 12;
   localparam int OW   = W - 2;
   localparam int NPIX = (W - 2) * (H - 2);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;
   logic [71:0]   kernel = '0;
   logic          mem_r_en, out_valid, busy, done;
   logic [AW-1:0] mem_addr, out_addr;
   logic [7:0]    mem_rdata = '0;
   logic [7:0]    out_data;

   logic [7:0]    img [W*H];
   int            mk [9];
   int            got [NPIX];
   int            errors = 0, checks = 0;
   int            exp_idx = 0, cyc = 0;
   int            run_len = 0, prev_hs = -1, done_cnt = 0, done_cyc = 0, start_cyc = 0;
   bit            stall = 1'b0;

   conv3x3_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SHIFT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .kernel(kernel),
      .mem_r_en(mem_r_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Image RAM: registered read, data valid the cycle after r_en
   always @(posedge clk) if (mem_r_en) mem_rdata <= img[mem_addr];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: direct 3x3 sum over the image, shift, clamp
   function automatic int model(input int idx);
      int r, c, s;
      r = idx / OW;
      c = idx % OW;
      s = 0;
      for (int dy = 0; dy < 3; dy++)
         for (int dx = 0; dx < 3; dx++)
            s += int'(img[(r + dy) * W + c + dx]) * mk[3 * dy + dx];
      s = s >>> 4;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      return s;
   endfunction

   // Compare process: handshakes, read-burst length, pixel period, done pulses
   always @(negedge clk) begin
      if (rst) begin
         run_len = 0;
         prev_hs = -1;
         stall   = 1'b0;
      end else begin
         if (mem_r_en) begin
            run_len++;
            check("ren_while_busy", int'(busy), 1);
         end else if (run_len != 0) begin
            check("read_burst_len", run_len, 9);
            run_len = 0;
         end
         if (out_valid && !out_ready) stall = 1'b1;
         if (out_valid && out_ready) begin
            $display("hs idx=%0d out_addr=%0d out_data=%0d", exp_idx, out_addr, out_data);
            check("out_addr", int'(out_addr), exp_idx);
            if (exp_idx < NPIX) begin
               check("out_data", int'(out_data), model(exp_idx));
               got[exp_idx] = int'(out_data);
            end else begin
               check("extra_result", exp_idx, NPIX - 1);
            end
            if (prev_hs >= 0 && !stall) check("pixel_period", cyc - prev_hs, 11);
            prev_hs = cyc;
            stall   = 1'b0;
            exp_idx++;
         end
         if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
         end
      end
   end

   task automatic fill_img(input bit ramp, input int val);
      for (int a = 0; a < W * H; a++) img[a] = ramp ? 8'(a) : 8'(val);
   endtask

   task automatic set_kernel(input int others, input int centre);
      for (int k = 0; k < 9; k++) mk[k] = others;
      mk[4] = centre;
   endtask

   task automatic start_run();
      @(posedge clk); #1;
      for (int k = 0; k < 9; k++) kernel[8*k +: 8] = 8'(mk[k]);
      exp_idx   = 0;
      done_cnt  = 0;
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idx(input int n, input int budget);
      int k;
      k = 0;
      while (exp_idx < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check("wait_results_timeout", exp_idx >= n ? 1 : 0, 1);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_data"}, int'(out_data), 0);
      check({tag, "_out_addr"}, int'(out_addr), 0);
      check({tag, "_mem_r_en"}, int'(mem_r_en), 0);
      check({tag, "_mem_addr"}, int'(mem_addr), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_idx = 0;
   endtask

   initial begin
      int seq [9];
      int k;
      seq = '{0, 1, 2, 64, 65, 66, 128, 129, 130};

      #2;
      check_quiet("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Identity kernel on a ramp image with backpressure on the first result
      fill_img(1'b1, 0);
      set_kernel(0, 16);
      out_ready = 1'b0;
      start_run();
      for (int t = 0; t < 9; t++) begin
         check("first_rd_en", int'(mem_r_en), 1);
         check("first_rd_addr", int'(mem_addr), seq[t]);
         @(posedge clk); #1;
      end
      check("drain_rd_en", int'(mem_r_en), 0);
      check("drain_valid", int'(out_valid), 0);
      check("drain_busy", int'(busy), 1);
      for (int s = 0; s < 5; s++) begin
         @(posedge clk); #1;
         check("stall_valid", int'(out_valid), 1);
         check("stall_data", int'(out_data), 65);
         check("stall_addr", int'(out_addr), 0);
         check("stall_rd_en", int'(mem_r_en), 0);
      end
      @(posedge clk); #1;
      check("stall6_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("resume_valid", int'(out_valid), 0);
      check("resume_rd_en", int'(mem_r_en), 1);
      check("resume_rd_addr", int'(mem_addr), 1);

      // Asynchronous reset during the reads of pixel 10
      wait_idx(10, 200);
      check("pre_rst_rd_en", int'(mem_r_en), 1);
      #2 rst = 1'b1;
      #1;
      check_quiet("async_rst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_idx = 0;

      // Restart; a start pulse with another kernel mid-run must be ignored
      start_run();
      wait_idx(5, 100);
      @(posedge clk); #1;
      kernel = {9{8'd1}};
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_stray_start", int'(busy), 1);
      wait_idx(63, 63 * 11 + 50);
      check("identity_px0", got[0], 65);
      check("identity_px61", got[61], 126);
      check("identity_px62", got[62], 129);
      do_reset();

      // Saturation high: all taps 127 on a white image
      fill_img(1'b0, 255);
      set_kernel(127, 127);
      start_run();
      wait_idx(1, 40);
      check("sat_high_px0", got[0], 255);
      do_reset();

      // Saturation low: centre -128 on a white image
      set_kernel(0, -128);
      start_run();
      wait_idx(1, 40);
      check("sat_low_px0", got[0], 0);
      do_reset();

      // Box kernel over a constant image, full run to done
      fill_img(1'b0, 200);
      set_kernel(1, 1);
      start_run();
      k = 0;
      while (done_cnt == 0 && k < 43000) begin
         @(posedge clk); #1;
         k++;
      end
      check("done_seen", done_cnt, 1);
      repeat (3) @(posedge clk);
      #1;
      check("done_pulse_cycles", done_cnt, 1);
      check("done_cycle", done_cyc - start_cyc, 11 * NPIX + 1);
      check("box_result_count", exp_idx, NPIX);
      check("box_px0", got[0], 112);
      check("box_px_last", got[NPIX-1], 112);
      check("idle_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
